cordic_pipe: RTL and testbench

- Full-circle, parametrised CORDIC pipeline: STAGES micro-rotation stages, plus quadrant pre-rotation and optional gain compensation.
- Mode is selectable per sample: rotation (sin/cos, vector rotate) or vectoring (magnitude/atan2).
- Uses valid/ready handshakes with per-stage bubble collapsing and carries a user tag.
- Sits between sample sources (NCO, mixers) and consumers in the DSP datapath.

---
 rtl/cordic_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_cordic_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_pipe.sv
// Full-circle CORDIC pipeline: quadrant pre-rotation, STAGES micro-rotations and
// optional 1/K gain stage, with per-stage valid/ready and bubble collapsing.
module cordic_pipe #(
   parameter int DATA_W    = 16,
   parameter int ANG_W     = 16,
   parameter int STAGES    = 16,
   parameter int GAIN_COMP = 1,
   parameter int TAG_W     = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_mode,
   input  logic signed [DATA_W-1:0] in_x,
   input  logic signed [DATA_W-1:0] in_y,
   input  logic signed [ANG_W-1:0]  in_angle,
   input  logic        [TAG_W-1:0]  in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_mode,
   output logic signed [DATA_W-1:0] out_x,
   output logic signed [DATA_W-1:0] out_y,
   output logic signed [ANG_W-1:0]  out_angle,
   output logic        [TAG_W-1:0]  out_tag
);

   localparam int XW = DATA_W + 2;
   localparam int ZW = ANG_W + 1;
   localparam int PW = 2 * XW;
   localparam int GC = (GAIN_COMP != 0) ? 1 : 0;
   localparam int L  = 1 + STAGES + GC;

   function automatic real pow2r(input int n);
      real p;
      p = 1.0;
      for (int j = 0; j < n; j++) p = p * 2.0;
      return p;
   endfunction

   // atan(2^-i) by Taylor series; converges quickly for i >= 1
   function automatic real atan_pow2(input int i);
      real t, term, sum;
      if (i == 0) return 3.14159265358979323846 / 4.0;
      t    = 1.0 / pow2r(i);
      term = t;
      sum  = 0.0;
      for (int n = 0; n < 40; n++) begin
         sum  = sum + (((n % 2) != 0) ? -1.0 : 1.0) * term / (2 * n + 1);
         term = term * t * t;
      end
      return sum;
   endfunction

   function automatic logic [STAGES*ZW-1:0] atan_table();
      logic [STAGES*ZW-1:0] t;
      real scale;
      t     = '0;
      scale = pow2r(ANG_W - 1) / 3.14159265358979323846;
      for (int i = 0; i < STAGES; i++)
         t[i*ZW +: ZW] = ZW'($rtoi(atan_pow2(i) * scale + 0.5));
      return t;
   endfunction

   localparam logic [STAGES*ZW-1:0] ATAN_TAB = atan_table();
   localparam int                   GAIN_K   = $rtoi(0.607253 * pow2r(DATA_W) + 0.5);
   localparam logic signed [XW-1:0] GAIN_C   = XW'(GAIN_K);
   localparam logic signed [PW-1:0] ROUND_C  = {{(PW-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [ZW-1:0] PI_Z     = {2'b01, {(ANG_W-1){1'b0}}};
   localparam logic signed [ZW-1:0] HALF_PI  = {3'b001, {(ANG_W-2){1'b0}}};
   localparam logic signed [XW-1:0] MAX_D    = {{(XW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [XW-1:0] MIN_D    = {{(XW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic [L-1:0]          v, adv, mode_q, zero_q;
   logic signed [XW-1:0]  x_q [L];
   logic signed [XW-1:0]  y_q [L];
   logic signed [ZW-1:0]  z_q [L];
   logic [TAG_W-1:0]      tag_q [L];
   logic signed [XW-1:0]  x_d [L];
   logic signed [XW-1:0]  y_d [L];
   logic signed [ZW-1:0]  z_d [L];
   logic signed [XW-1:0]  ix, iy;
   logic signed [ZW-1:0]  ia;

   // Stage k may load when it is empty or its successor is moving
   always_comb begin : adv_chain
      logic c;
      adv      = '0;
      c        = ~v[L-1] | out_ready;
      adv[L-1] = c;
      for (int k = L - 2; k >= 0; k--) begin
         c      = ~v[k] | c;
         adv[k] = c;
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = v[L-1];

   always_comb begin
      for (int k = 0; k < L; k++) begin
         x_d[k] = '0;
         y_d[k] = '0;
         z_d[k] = '0;
      end
      ix = XW'(in_x);
      iy = XW'(in_y);
      ia = ZW'(in_angle);

      x_d[0] = ix;
      y_d[0] = iy;
      z_d[0] = '0;
      if (!in_mode) begin
         z_d[0] = ia;
         if (ia > HALF_PI) begin
            x_d[0] = -ix;
            y_d[0] = -iy;
            z_d[0] = ia - PI_Z;
         end else if (ia < -HALF_PI) begin
            x_d[0] = -ix;
            y_d[0] = -iy;
            z_d[0] = ia + PI_Z;
         end
      end else if (ix[XW-1]) begin
         x_d[0] = -ix;
         y_d[0] = -iy;
         z_d[0] = iy[XW-1] ? -PI_Z : PI_Z;
      end

      // micro-rotation i = k-1 lives in pipeline stage k
      for (int k = 1; k <= STAGES; k++) begin
         if (mode_q[k-1] ? y_q[k-1][XW-1] : ~z_q[k-1][ZW-1]) begin
            x_d[k] = x_q[k-1] - (y_q[k-1] >>> (k - 1));
            y_d[k] = y_q[k-1] + (x_q[k-1] >>> (k - 1));
            z_d[k] = z_q[k-1] - $signed(ATAN_TAB[(k-1)*ZW +: ZW]);
         end else begin
            x_d[k] = x_q[k-1] + (y_q[k-1] >>> (k - 1));
            y_d[k] = y_q[k-1] - (x_q[k-1] >>> (k - 1));
            z_d[k] = z_q[k-1] + $signed(ATAN_TAB[(k-1)*ZW +: ZW]);
         end
      end

      if (GC == 1) begin
         x_d[L-1] = XW'((PW'(x_q[L-2]) * PW'(GAIN_C) + ROUND_C) >>> DATA_W);
         y_d[L-1] = XW'((PW'(y_q[L-2]) * PW'(GAIN_C) + ROUND_C) >>> DATA_W);
         z_d[L-1] = z_q[L-2];
      end
   end

   // Data registers only load with a real sample, so outputs hold between results
   always_ff @(posedge clk) begin
      if (reset) begin
         v      <= '0;
         mode_q <= '0;
         zero_q <= '0;
         for (int k = 0; k < L; k++) begin
            x_q[k]   <= '0;
            y_q[k]   <= '0;
            z_q[k]   <= '0;
            tag_q[k] <= '0;
         end
      end else begin
         if (adv[0]) begin
            v[0] <= in_valid;
            if (in_valid) begin
               x_q[0]    <= x_d[0];
               y_q[0]    <= y_d[0];
               z_q[0]    <= z_d[0];
               mode_q[0] <= in_mode;
               zero_q[0] <= in_mode & (in_x == '0) & (in_y == '0);
               tag_q[0]  <= in_tag;
            end
         end
         for (int k = 1; k < L; k++) begin
            if (adv[k]) begin
               v[k] <= v[k-1];
               if (v[k-1]) begin
                  x_q[k]    <= x_d[k];
                  y_q[k]    <= y_d[k];
                  z_q[k]    <= z_d[k];
                  mode_q[k] <= mode_q[k-1];
                  zero_q[k] <= zero_q[k-1];
                  tag_q[k]  <= tag_q[k-1];
               end
            end
         end
      end
   end

   function automatic logic signed [DATA_W-1:0] sat(input logic signed [XW-1:0] a);
      if (a > MAX_D) return MAX_D[DATA_W-1:0];
      if (a < MIN_D) return MIN_D[DATA_W-1:0];
      return a[DATA_W-1:0];
   endfunction

   // A zero vector has no defined angle; report 0 instead of the accumulated table sum
   always_comb begin
      out_x     = sat(x_q[L-1]);
      out_y     = sat(y_q[L-1]);
      out_angle = zero_q[L-1] ? '0 : z_q[L-1][ANG_W-1:0];
      out_mode  = mode_q[L-1];
      out_tag   = tag_q[L-1];
   end

endmodule

// File: tb/tb_cordic_pipe.sv
// Self-checking bench for cordic_pipe: directed points, saturation instance,
// randomized backpressure against a floating-point reference, reset flush.
module tb_cordic_pipe;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int TW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset;
   logic                 in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
   logic signed [DW-1:0] in_x, in_y, out_x, out_y;
   logic signed [AW-1:0] in_angle, out_angle;
   logic [TW-1:0]        in_tag, out_tag;

   logic                 s_in_valid, s_in_ready, s_out_valid, s_out_mode;
   logic signed [DW-1:0] s_out_x, s_out_y;
   logic signed [AW-1:0] s_out_angle;
   logic [TW-1:0]        s_out_tag;

   cordic_pipe #(.DATA_W(DW), .ANG_W(AW), .STAGES(16), .GAIN_COMP(1), .TAG_W(TW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_x(in_x), .in_y(in_y), .in_angle(in_angle), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
      .out_x(out_x), .out_y(out_y), .out_angle(out_angle), .out_tag(out_tag));

   cordic_pipe #(.DATA_W(DW), .ANG_W(AW), .STAGES(16), .GAIN_COMP(0), .TAG_W(TW)) dut_raw (
      .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_mode(1'b0),
      .in_x(16'sd32767), .in_y(16'sd32767), .in_angle(16'sd0), .in_tag(4'd5),
      .out_valid(s_out_valid), .out_ready(1'b1), .out_mode(s_out_mode),
      .out_x(s_out_x), .out_y(s_out_y), .out_angle(s_out_angle), .out_tag(s_out_tag));

   int n_chk = 0;
   int n_err = 0;
   int tag_ctr = 0;

   task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
      int d;
      n_chk++;
      d = got - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   typedef struct {
      bit mode;
      int x, y, a, tag, txy, ta;
   } exp_t;
   exp_t sb[$];

   function automatic int rnd(input real r);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
   endfunction

   function automatic int sat16(input int v);
      return (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
   endfunction

   function automatic int wrap16(input int v);
      logic [15:0] t;
      t = v[15:0];
      return int'($signed(t));
   endfunction

   // Ideal rotation / polar conversion with unit gain
   function automatic exp_t model(input bit mode, input int x, input int y, input int ang, input int tag);
      exp_t e;
      real  pi, a, rx, ry;
      pi    = 3.14159265358979;
      e.mode = mode;
      e.tag  = tag % 16;
      e.txy  = 20;
      if (!mode) begin
         a    = real'(ang) * pi / 32768.0;
         rx   = real'(x) * $cos(a) - real'(y) * $sin(a);
         ry   = real'(x) * $sin(a) + real'(y) * $cos(a);
         e.x  = sat16(rnd(rx));
         e.y  = sat16(rnd(ry));
         e.a  = 0;
         e.ta = 6;
      end else begin
         e.x  = sat16(rnd($sqrt(real'(x) * real'(x) + real'(y) * real'(y))));
         e.y  = 0;
         e.a  = wrap16(rnd($atan2(real'(y), real'(x)) * 32768.0 / pi));
         e.ta = 24;
      end
      return e;
   endfunction

   task automatic pick_sample();
      in_mode = 1'($urandom % 2);
      if (!in_mode) begin
         in_x     = DW'(int'($urandom_range(0, 32000)) - 16000);
         in_y     = DW'(int'($urandom_range(0, 32000)) - 16000);
         in_angle = AW'(int'($urandom_range(0, 65535)) - 32768);
      end else begin
         do begin
            in_x = DW'(int'($urandom_range(0, 40000)) - 20000);
            in_y = DW'(int'($urandom_range(0, 40000)) - 20000);
         end while ((in_x < 8000 && in_x > -8000) && (in_y < 8000 && in_y > -8000));
         in_angle = AW'($urandom);
      end
      in_tag = TW'(tag_ctr);
   endtask

   task automatic run_one(input string nm, input bit mode, input int x, input int y, input int ang,
                          input int ex, input int ey, input int ea, input int txy, input int ta);
      int n;
      @(negedge clk);
      in_valid = 1'b1; in_mode = mode; out_ready = 1'b1;
      in_x = DW'(x); in_y = DW'(y); in_angle = AW'(ang); in_tag = TW'(tag_ctr);
      #1 chk({nm, "_rdy"}, int'(in_ready), 1);
      @(posedge clk);
      n = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk({nm, "_lat"}, n, 18);
      chk({nm, "_x"}, int'(out_x), ex, txy);
      chk({nm, "_y"}, int'(out_y), ey, txy);
      chk({nm, "_ang"}, wrap16(int'(out_angle) - ea), 0, ta);
      chk({nm, "_tag"}, int'(out_tag), tag_ctr % 16);
      chk({nm, "_mode"}, int'(out_mode), int'(mode));
      tag_ctr++;
   endtask

   task automatic stream(input int nsamp, input bit full);
      int   sent, recv, acc_first, acc_last, out_first, out_last;
      int   hx, hy, ha, ht;
      bit   have, stall;
      exp_t e;
      sent = 0; recv = 0; have = 0; stall = 0;
      acc_first = -1; acc_last = -1; out_first = -1; out_last = -1;
      hx = 0; hy = 0; ha = 0; ht = 0;
      for (int cyc = 0; cyc < 20000 && recv < nsamp; cyc++) begin
         @(negedge clk);
         if (!have && sent < nsamp && (full || ($urandom % 3) != 0)) begin
            pick_sample();
            have = 1;
         end
         in_valid  = have;
         out_ready = full ? 1'b1 : (($urandom % 4) != 0);
         #1;
         if (stall) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_x", int'(out_x), hx);
            chk("hold_y", int'(out_y), hy);
            chk("hold_ang", int'(out_angle), ha);
            chk("hold_tag", int'(out_tag), ht);
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(in_mode, int'(in_x), int'(in_y), int'(in_angle), tag_ctr));
            sent++;
            tag_ctr++;
            have = 0;
            if (acc_first < 0) acc_first = cyc;
            acc_last = cyc;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("spurious_out", 1, 0);
            else begin
               e = sb.pop_front();
               chk("tag", int'(out_tag), e.tag);
               chk("mode", int'(out_mode), int'(e.mode));
               chk("x", int'(out_x), e.x, e.txy);
               chk("y", int'(out_y), e.y, e.txy);
               chk("ang", wrap16(int'(out_angle) - e.a), 0, e.ta);
            end
            recv++;
            if (out_first < 0) out_first = cyc;
            out_last = cyc;
         end
         stall = out_valid && !out_ready;
         hx = int'(out_x); hy = int'(out_y); ha = int'(out_angle); ht = int'(out_tag);
      end
      in_valid = 1'b0;
      chk("recv_count", recv, nsamp);
      chk("sb_empty", sb.size(), 0);
      if (full) begin
         chk("tput_in", acc_last - acc_first + 1, nsamp);
         chk("tput_out", out_last - out_first + 1, nsamp);
      end
   endtask

   initial begin
      int n, cnt;
      reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
      in_x = '0; in_y = '0; in_angle = '0; in_tag = '0; s_in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_x", int'(out_x), 0);
      chk("rst_y", int'(out_y), 0);
      chk("rst_ang", int'(out_angle), 0);
      chk("rst_tag", int'(out_tag), 0);
      chk("rst_mode", int'(out_mode), 0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("rdy_after_rst", int'(in_ready), 1);

      run_one("pi4", 0, 16384, 0, 'h2000, 11585, 11585, 0, 4, 2);
      run_one("negpi", 0, 16384, 0, -32768, -16384, 0, 0, 4, 4);
      run_one("3pi4", 0, 16384, 0, 'h6000, -11585, 11585, 0, 4, 4);
      run_one("vec", 1, -12000, 9000, 0, 15000, 0, 26056, 4, 3);
      run_one("vec0", 1, 0, 0, 0, 0, 0, 0, 0, 0);

      @(negedge clk);
      s_in_valid = 1'b1;
      @(posedge clk);
      n = 1;
      @(negedge clk);
      s_in_valid = 1'b0;
      while (!s_out_valid && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("sat_lat", n, 17);
      chk("sat_x", int'(s_out_x), 32767);
      chk("sat_y", int'(s_out_y), 32767);

      stream(200, 1'b0);
      stream(60, 1'b1);

      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         pick_sample();
         in_valid = 1'b1;
         tag_ctr++;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      reset     = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst2_rdy", int'(in_ready), 1);
      chk("rst2_x", int'(out_x), 0);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("rst2_flush", cnt, 0);
      run_one("post_rst", 0, 16384, 0, 'h2000, 11585, 11585, 0, 4, 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
